// File: rtl/npu_act_pkg.sv
// Shared definitions for the piecewise-linear activation unit: default
// geometry, accumulator sizing, coefficient word layout, and the round and
// saturate helpers used by the lane datapath.
package npu_act_pkg;

    localparam int LANES_DEF       = 4;
    localparam int DATA_WIDTH_DEF  = 8;
    localparam int COE_A_WIDTH_DEF = 8;
    localparam int COE_B_WIDTH_DEF = 16;
    localparam int SEG_NUM_DEF     = 8;
    localparam int OUT_WIDTH_DEF   = 16;
    localparam int SHIFT_WIDTH_DEF = 4;

    // Wide working type for rounding/saturation; comfortably above ACC_W+1.
    localparam int WIDE_W = 64;
    typedef logic signed [WIDE_W-1:0] wide_t;

    // The accumulator holds the full product plus one guard bit for the offset add.
    function automatic int calc_acc_w(input int a_w, input int dw, input int b_w);
        return (((a_w + dw) > b_w) ? (a_w + dw) : b_w) + 1;
    endfunction

    localparam int SEG_AW = $clog2(SEG_NUM_DEF);
    localparam int ACC_W  = calc_acc_w(COE_A_WIDTH_DEF, DATA_WIDTH_DEF, COE_B_WIDTH_DEF);

    // Coefficient word is {a, b} with the slope in the MSBs.
    localparam int COE_W     = COE_A_WIDTH_DEF + COE_B_WIDTH_DEF;
    localparam int COE_B_LSB = 0;
    localparam int COE_A_LSB = COE_B_WIDTH_DEF;

    // Arithmetic right shift with round-half-up; sh == 0 passes through.
    function automatic wide_t round_shr(input wide_t value, input int sh);
        wide_t bias;
        if (sh <= 0) begin
            return value;
        end
        bias = wide_t'(1) << (sh - 1);
        return (value + bias) >>> sh;
    endfunction

    // Clamp a signed value into the range of a signed field of the given width.
    function automatic wide_t sat_s(input wide_t value, input int width);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) << (width - 1)) - wide_t'(1);
        lo = -(wide_t'(1) << (width - 1));
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/pwl_lane.sv
// One lane of the activation datapath after coefficient lookup:
// stage 2 forms a*x + b at accumulator width, stage 3 rounds, shifts and
// saturates to the output width. Stage enables come from the shared control.
module pwl_lane
    import npu_act_pkg::*;
#(
    parameter int DW   = DATA_WIDTH_DEF,
    parameter int A_W  = COE_A_WIDTH_DEF,
    parameter int B_W  = COE_B_WIDTH_DEF,
    parameter int OW   = OUT_WIDTH_DEF,
    parameter int SHW  = SHIFT_WIDTH_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  en2,
    input  logic                  en3,
    input  logic signed [DW-1:0]  x,
    input  logic signed [A_W-1:0] a,
    input  logic signed [B_W-1:0] b,
    input  logic        [SHW-1:0] sh,
    output logic signed [OW-1:0]  y
);

    localparam int LANE_ACC_W = calc_acc_w(A_W, DW, B_W);

    logic signed [LANE_ACC_W-1:0] a_ext;
    logic signed [LANE_ACC_W-1:0] x_ext;
    logic signed [LANE_ACC_W-1:0] b_ext;
    logic signed [LANE_ACC_W-1:0] sum_d;
    logic signed [LANE_ACC_W-1:0] sum_q;
    logic        [SHW-1:0]        sh_q;
    logic signed [OW-1:0]         y_d;

    // Multiply-add at accumulator width; the product cannot overflow ACC_W.
    always_comb begin
        a_ext = {{(LANE_ACC_W - A_W){a[A_W-1]}}, a};
        x_ext = {{(LANE_ACC_W - DW){x[DW-1]}}, x};
        b_ext = {{(LANE_ACC_W - B_W){b[B_W-1]}}, b};
        sum_d = a_ext * x_ext + b_ext;
    end

    // Stage 2 register: sum and the shift amount that travels with it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sum_q <= '0;
            sh_q  <= '0;
        end else if (en2) begin
            sum_q <= sum_d;
            sh_q  <= sh;
        end
    end

    // Round-shift then saturate; done in the wide type so the rounding add never wraps.
    always_comb begin
        y_d = OW'(sat_s(round_shr(wide_t'(sum_q), int'(sh_q)), OW));
    end

    // Stage 3 register: the lane's output, held while downstream stalls.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            y <= '0;
        end else if (en3) begin
            y <= y_d;
        end
    end

endmodule

// File: rtl/pwl_act_unit.sv
// Multi-lane piecewise-linear activation unit. Holds the runtime-writable
// coefficient table, does the per-lane segment lookup in stage 1, and runs
// the three-stage valid/enable pipeline that feeds the lane datapaths.
module pwl_act_unit
    import npu_act_pkg::*;
#(
    parameter int LANES       = LANES_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int COE_A_WIDTH = COE_A_WIDTH_DEF,
    parameter int COE_B_WIDTH = COE_B_WIDTH_DEF,
    parameter int SEG_NUM     = SEG_NUM_DEF,
    parameter int OUT_WIDTH   = OUT_WIDTH_DEF,
    parameter int SHIFT_WIDTH = SHIFT_WIDTH_DEF
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_cfg_we,
    input  logic [$clog2(SEG_NUM)-1:0]         i_cfg_addr,
    input  logic [COE_A_WIDTH+COE_B_WIDTH-1:0] i_cfg_coe,
    input  logic [SHIFT_WIDTH-1:0]             i_cfg_shift,
    input  logic                               i_valid,
    output logic                               o_ready,
    input  logic [LANES*DATA_WIDTH-1:0]        i_dat,
    output logic                               o_valid,
    input  logic                               i_ready,
    output logic [LANES*OUT_WIDTH-1:0]         o_dat,
    output logic                               o_busy
);

    localparam int DW     = DATA_WIDTH;
    localparam int OW     = OUT_WIDTH;
    localparam int T_AW   = $clog2(SEG_NUM);
    localparam int T_CW   = COE_A_WIDTH + COE_B_WIDTH;
    localparam int A_LSB  = COE_B_WIDTH;
    localparam logic [T_CW-1:0] COE_IDENT =
        {{(COE_A_WIDTH-1){1'b0}}, 1'b1, {COE_B_WIDTH{1'b0}}};

    logic [T_CW-1:0]        coe_tab [SEG_NUM];
    logic                   v1, v2, v3;
    logic                   en1, en2, en3;
    logic [SHIFT_WIDTH-1:0] sh1;

    assign en3     = !v3 || i_ready;
    assign en2     = !v2 || en3;
    assign en1     = !v1 || en2;
    assign o_ready = en1;
    assign o_valid = v3;
    assign o_busy  = v1 || v2 || v3;

    // Coefficient table: identity on reset, one entry written per cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < SEG_NUM; i++) begin
                coe_tab[i] <= COE_IDENT;
            end
        end else if (i_cfg_we) begin
            coe_tab[i_cfg_addr] <= i_cfg_coe;
        end
    end

    // Stage valids; each stage only moves when the one after it can take the beat.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (en1) v1 <= i_valid;
            if (en2) v2 <= v1;
            if (en3) v3 <= v2;
        end
    end

    // Per-beat shift amount captured at accept.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sh1 <= '0;
        end else if (en1 && i_valid) begin
            sh1 <= i_cfg_shift;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic        [DW-1:0]          x_raw;
        logic        [DW-1:0]          x_ofs;
        logic        [T_AW-1:0]        seg;
        logic        [T_CW-1:0]        ent;
        logic signed [DW-1:0]          x1;
        logic signed [COE_A_WIDTH-1:0] a1;
        logic signed [COE_B_WIDTH-1:0] b1;
        logic signed [OW-1:0]          y;

        // Flipping the sign bit gives offset binary; its top bits are the segment.
        assign x_raw = i_dat[k*DW +: DW];
        assign x_ofs = x_raw ^ {1'b1, {(DW-1){1'b0}}};
        assign seg   = T_AW'(x_ofs >> (DW - T_AW));
        assign ent   = coe_tab[seg];

        // Stage 1: latch sample and its looked-up coefficients (pre-write table contents).
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                x1 <= '0;
                a1 <= '0;
                b1 <= '0;
            end else if (en1 && i_valid) begin
                x1 <= x_raw;
                a1 <= ent[A_LSB +: COE_A_WIDTH];
                b1 <= ent[COE_B_WIDTH-1:0];
            end
        end

        pwl_lane #(
            .DW  (DW),
            .A_W (COE_A_WIDTH),
            .B_W (COE_B_WIDTH),
            .OW  (OW),
            .SHW (SHIFT_WIDTH)
        ) u_lane (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .en2     (en2),
            .en3     (en3),
            .x       (x1),
            .a       (a1),
            .b       (b1),
            .sh      (sh1),
            .y       (y)
        );

        assign o_dat[k*OW +: OW] = y;
    end

endmodule

// File: tb/tb_pwl_act_unit.sv
// Scoreboard bench for pwl_act_unit: the driver predicts each accepted beat
// from an integer reference model and queues it; a monitor pops and compares
// whenever a beat leaves the unit.
module tb_pwl_act_unit;
    import npu_act_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_cfg_we = 1'b0;
    logic [2:0]  i_cfg_addr = '0;
    logic [23:0] i_cfg_coe = '0;
    logic [3:0]  i_cfg_shift = '0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_dat = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [63:0] o_dat;
    logic        o_busy;

    int n_tests = 0;
    int n_fail  = 0;
    int n_beats = 0;
    int tab_a [8];
    int tab_b [8];
    logic [63:0] exp_q [$];

    always #5 i_clk = ~i_clk;

    pwl_act_unit dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_cfg_we    (i_cfg_we),
        .i_cfg_addr  (i_cfg_addr),
        .i_cfg_coe   (i_cfg_coe),
        .i_cfg_shift (i_cfg_shift),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_dat       (i_dat),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_dat       (o_dat),
        .o_busy      (o_busy)
    );

    function automatic void check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void model_identity();
        for (int i = 0; i < 8; i++) begin
            tab_a[i] = 1;
            tab_b[i] = 0;
        end
    endfunction

    // Reference: y = a[seg]*x + b[seg], rounded half up by 2^sh, clamped to 16 bits.
    function automatic longint ref_lane(input int x, input int sh);
        longint v, d, q;
        int s;
        s = (x + 128) / 32;
        v = longint'(tab_a[s]) * x + tab_b[s];
        if (sh > 0) begin
            d = longint'(1) << sh;
            v = v + d / 2;
            q = v / d;
            if (v < 0 && q * d != v) q = q - 1;
            v = q;
        end
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return v;
    endfunction

    function automatic logic [63:0] ref_beat(input logic [31:0] d, input int sh);
        logic [63:0] r;
        logic [7:0]  xb;
        longint      y;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            xb = d[k*8 +: 8];
            y  = ref_lane(int'($signed(xb)), sh);
            r[k*16 +: 16] = 16'(y);
        end
        return r;
    endfunction

    function automatic logic [31:0] pack4(input int l0, input int l1, input int l2, input int l3);
        return {l3[7:0], l2[7:0], l1[7:0], l0[7:0]};
    endfunction

    // One cycle of stimulus: drive at negedge, decide accept just before the posedge.
    task automatic cycle(input logic v, input logic [31:0] d, input int sh,
                         input logic we, input int addr, input int a, input int b,
                         input logic rdy, output logic acc);
        logic [23:0] coe;
        logic [7:0]  ab;
        logic [15:0] bb;
        @(negedge i_clk);
        ab = a[7:0];
        bb = b[15:0];
        coe = '0;
        coe[COE_A_LSB +: COE_A_WIDTH_DEF] = ab;
        coe[COE_B_LSB +: COE_B_WIDTH_DEF] = bb;
        i_valid     = v;
        i_dat       = d;
        i_cfg_shift = sh[3:0];
        i_cfg_we    = we;
        i_cfg_addr  = addr[2:0];
        i_cfg_coe   = coe;
        i_ready     = rdy;
        #1;
        acc = v && o_ready;
        if (acc) exp_q.push_back(ref_beat(d, sh));
        if (we) begin
            tab_a[addr[2:0]] = int'($signed(ab));
            tab_b[addr[2:0]] = int'($signed(bb));
        end
    endtask

    task automatic idle(input logic rdy);
        logic acc;
        cycle(1'b0, '0, 0, 1'b0, 0, 0, 0, rdy, acc);
    endtask

    task automatic wr(input int addr, input int a, input int b);
        logic acc;
        cycle(1'b0, '0, 0, 1'b1, addr, a, b, 1'b1, acc);
    endtask

    task automatic beat(input logic [31:0] d, input int sh);
        logic acc;
        cycle(1'b1, d, sh, 1'b0, 0, 0, 0, 1'b1, acc);
        check("beat_accepted", acc, 1);
    endtask

    task automatic drain(input string tag);
        bit done;
        done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            idle(1'b1);
            #2;
            if (exp_q.size() == 0 && !o_busy) done = 1;
        end
        check({tag, "_drain_done"}, done, 1);
        check({tag, "_busy_low"}, o_busy, 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_cfg_we = 1'b0;
        #1;
        check({tag, "_rst_o_valid"}, o_valid, 0);
        check({tag, "_rst_o_busy"}, o_busy, 0);
        check({tag, "_rst_o_dat"}, o_dat, 0);
        exp_q.delete();
        model_identity();
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        check({tag, "_rst_o_ready"}, o_ready, 1);
    endtask

    // Monitor: compare every beat that leaves against the head of the queue.
    initial begin
        logic [63:0] e;
        logic [15:0] got_l, exp_l;
        forever begin
            @(negedge i_clk);
            #2;
            if (i_rst_n && o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    for (int k = 0; k < 4; k++) begin
                        got_l = o_dat[k*16 +: 16];
                        exp_l = e[k*16 +: 16];
                        check($sformatf("beat%0d_lane%0d", n_beats, k),
                              longint'($signed(got_l)), longint'($signed(exp_l)));
                    end
                    n_beats++;
                end
            end
        end
    end

    initial begin
        logic acc;
        logic [31:0] st_beats [6];
        int sent;
        model_identity();

        // Reset state
        repeat (2) @(negedge i_clk);
        #1;
        check("reset_o_valid", o_valid, 0);
        check("reset_o_dat", o_dat, 0);
        check("reset_o_busy", o_busy, 0);
        i_rst_n = 1'b1;
        #1;
        check("reset_o_ready", o_ready, 1);

        // Identity pass-through with latency check
        beat(pack4(5, -3, 127, -128), 0);
        idle(1'b1);
        check("latency_c1", o_valid, 0);
        idle(1'b1);
        check("latency_c2", o_valid, 0);
        idle(1'b1);
        check("latency_c3", o_valid, 1);
        drain("t1");

        // Programmed segments
        wr(4, 3, 10);
        wr(3, -2, 0);
        beat(pack4(20, -1, 0, -1), 0);
        drain("t2");

        // Saturation at both rails
        wr(7, 127, 32767);
        wr(0, 127, -32768);
        beat(pack4(127, -128, 127, -128), 0);
        drain("t3");

        // Rounding shift on identity table
        do_reset("t4");
        beat(pack4(6, -6, -7, 2), 2);
        drain("t4");

        // Backpressure: three beats fit, then the unit stalls
        for (int i = 0; i < 6; i++) st_beats[i] = $urandom;
        sent = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, st_beats[sent], 0, 1'b0, 0, 0, 0, 1'b0, acc);
            if (acc) sent++;
        end
        check("stall_accepted", sent, 3);
        check("stall_o_ready", o_ready, 0);
        check("stall_o_busy", o_busy, 1);
        for (int i = 0; i < 20 && sent < 6; i++) begin
            cycle(1'b1, st_beats[sent], 0, 1'b0, 0, 0, 0, 1'b1, acc);
            if (acc) sent++;
        end
        check("stall_all_sent", sent, 6);
        drain("t5");

        // Write to the segment being looked up in the same cycle
        cycle(1'b1, pack4(1, 1, 1, 1), 0, 1'b1, 4, 5, 7, 1'b1, acc);
        check("t6_accept_old", acc, 1);
        beat(pack4(1, 1, 1, 1), 0);
        drain("t6");

        // Reset with a full pipeline
        for (int i = 0; i < 4; i++) cycle(1'b1, $urandom, 1, 1'b0, 0, 0, 0, 1'b0, acc);
        check("t6_full_o_valid", o_valid, 1);
        do_reset("t6");
        beat(pack4(1, -50, 100, -128), 0);
        drain("t6_post");

        // Randomized traffic with interleaved table writes
        for (int i = 0; i < 500; i++) begin
            logic v, we, rdy;
            int sh;
            v   = ($urandom % 4) != 0;
            rdy = ($urandom % 3) != 0;
            we  = ($urandom % 8) == 0;
            sh  = (($urandom % 3) == 0) ? int'($urandom % 16) : int'($urandom % 4);
            cycle(v, $urandom, sh, we, int'($urandom % 8), int'($urandom), int'($urandom), rdy, acc);
        end
        drain("rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
